instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage directly downstream of `programCounter`. Samples the current PC, issues one request at a time to instruction memory over a req/ack handshake, and pulses `incrEnable` so the PC advances. Fetched words go into a small in-order buffer and are handed to decode over a valid/ready handshake. The block discards stale work on flush and can optionally predecode unconditional branches to drive the PC's `Branch`/`branchImmediate` inputs.

## Interface
- `DEPTH`, 2: fetch buffer entries (≥2, power of two).
- `AW`, 32: address/PC width.

- `clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `pc`  in  AW  current PC (`programCounter.currData`).
- `incrEnable`  out  1  PC advance pulse to `programCounter`.
- `imem_req`  out  1  one-cycle request strobe to instruction memory.
- `imem_addr`  out  AW  request address, held from strobe until ack.
- `imem_ack`  in  1  read data valid, one cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `flush`  in  1  discard buffer and in-flight fetch (PC rewrite).
- `inst_valid`  out  1  buffer head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  32  head instruction.
- `inst_pc`  out  AW  address of head instruction.
- `Branch`  out  1  predecoded branch, to `programCounter.Branch`.
- `branchImmediate`  out  24  branch offset field, to `programCounter`.

## Operation
- States: IDLE, WAIT, DROP. Reset → IDLE.
- IDLE: if `count + 0 < DEPTH` and no `flush`/internal flush → assert `imem_req` and `incrEnable` for 1 cycle, latch `imem_addr <= pc`, go WAIT. Otherwise stay in IDLE with no request.
- WAIT: on `imem_ack` → push {`imem_rdata`, `imem_addr`} into buffer, go IDLE. `flush` without ack → DROP. `flush` with ack → data discarded, go IDLE.
- DROP: on `imem_ack` → data discarded, go IDLE. Further `flush` in DROP has no extra effect.
- Space check guarantees a push never hits a full buffer. A pop and a push in the same cycle are both honoured.
- Pop when `inst_valid && inst_ready`. Buffer is FIFO with wrap-around pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
- `flush` (or internal branch flush) clears the buffer at the edge: count=0, pointers=0. Flush overrides push and pop in the same cycle.
- `inst`/`inst_pc` reflect head storage (reset to 0). They are meaningful only when `inst_valid`.

## Timing
- Reset values: state IDLE, `imem_req`=0, `incrEnable`=0, `imem_addr`=0, `inst_valid`=0, buffer empty, `Branch`=0, `branchImmediate`=0.
- `imem_req`, `incrEnable`: registered-free combinational from state/count. PC updates at the same edge the request is issued.
- Minimum fetch cadence: 2 cycles per instruction (request cycle, ack cycle ≥1 later). An ack in the cycle after request gives 2-cycle throughput.
- Latency: `imem_ack` at edge N → `inst_valid` high in cycle N+1 when the buffer was empty.
- `inst_valid` is registered, from count≠0.
- Reset asserted mid-fetch: immediate return to IDLE, buffer empty. A late `imem_ack` after reset is ignored because the state is IDLE.

## Configuration
- `FETCH_PREDECODE_EN` defined: `Branch` = `inst_valid && inst_ready && inst[27:25]==3'b101 && inst[31:28]==4'b1110`, combinational. `branchImmediate` = `inst[23:0]` (otherwise 0). A predecoded branch acts as an internal flush at that edge.
- Not defined: `Branch`=0 and `branchImmediate`=0 constantly. Branching comes only through `flush`.

## Test plan
- Reset, `pc`=0x100, ack 1 cycle after each req, `inst_ready`=1 → addresses 0x100, 0x104… each fetched once. One `incrEnable` per `imem_req`. `inst_pc` matches.
- `inst_ready`=0 with DEPTH=2 → exactly 2 requests, then `imem_req` stays 0. Raising `inst_ready` resumes fetch after one pop.
- `flush` in WAIT, ack 3 cycles later → ack data never appears on `inst`. Buffer empty. Next request uses the new `pc`.
- `flush` coincident with `imem_ack` and a pop → buffer empty next cycle, state IDLE, no push.
- Predecode: head `inst`=0xEAFFFFFE popped → `Branch`=1 and `branchImmediate`=0xFFFFFE in that cycle; younger entry discarded. With the macro off, `Branch` stays 0.
- `Reset` asserted in WAIT, ack arrives after release → ack ignored, `inst_valid`=0, fetch restarts from `pc`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding imem req/ack fetcher feeding an in-order buffer to decode.
// Latency: imem_ack at edge N -> inst_valid in cycle N+1; best cadence one instruction per 2 cycles.
// Backpressure: no request while the buffer is full; decode stalls via inst_ready. Optional FETCH_PREDECODE_EN.
module instruction_fetch #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [AW-1:0] pc,
    output logic          incrEnable,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          flush,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          Branch,
    output logic [23:0]   branchImmediate
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];

    logic pop;
    logic push;
    logic br;
    logic flush_all;
    logic fetch_go;

    assign inst_valid = valid_q;
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign pop        = valid_q && inst_ready;

`ifdef FETCH_PREDECODE_EN
    // Unconditional branch (cond=AL, B/BL class) leaving the buffer redirects the PC.
    assign br              = pop && (inst[27:25] == 3'b101) && (inst[31:28] == 4'b1110);
    assign branchImmediate = br ? inst[23:0] : 24'd0;
`else
    assign br              = 1'b0;
    assign branchImmediate = 24'd0;
`endif
    assign Branch    = br;
    assign flush_all = flush || br;

    // A request is only launched with guaranteed buffer space, so a push can never overflow.
    // Gated by Reset so the PC does not run while the block is held in reset.
    assign fetch_go   = (state_q == IDLE) && (count_q < DEPTH_C) && !flush_all && !Reset;
    assign imem_req   = fetch_go;
    assign incrEnable = fetch_go;
    // The address is visible during the strobe cycle and held by addr_q until the ack.
    assign imem_addr  = fetch_go ? pc : addr_q;

    // Next-state logic for the request FSM; a flush turns the outstanding fetch into a discard.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_go) state_d = WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    push    = !flush_all;
                end else if (flush_all) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer pointer/count update; flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_all) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers: FSM, held request address, pointers, count and registered valid.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (fetch_go) addr_q <= pc;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
        end
    end

    // Buffer storage: instruction word plus the address it was fetched from.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule
